// File: rtl/tgt_pkg.sv
// Shared definitions for the target box sequencer: slot layout, FSM states
// and the coordinate clamp helper.
package tgt_pkg;

  localparam int COORD_W = 10;
  localparam int SLOT_W  = 4 * COORD_W + 1;  // 41 bits per slot
  localparam int MAX_TGT = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

  // Bit positions of the fields inside one slot of target_pos_bus.
  localparam int VALID_BIT = 40;
  localparam int BOT_MSB   = 39;
  localparam int BOT_LSB   = 30;
  localparam int RGT_MSB   = 29;
  localparam int RGT_LSB   = 20;
  localparam int TOP_MSB   = 19;
  localparam int TOP_LSB   = 10;
  localparam int LFT_MSB   = 9;
  localparam int LFT_LSB   = 0;

  // Packed view of one slot; member order matches the bit positions above.
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] bottom;
    logic [COORD_W-1:0] right;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] left;
  } slot_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_QUAL = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Limit a coordinate to the last valid pixel of the image.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                      input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/tgt_pick_lowest.sv
// Lowest-set-bit priority encoder over the 16 qualification flags.
// Gives the index and one-hot of the lowest request, plus a flag that is
// high when exactly one request bit is set.
module tgt_pick_lowest
  import tgt_pkg::*;
(
  input  logic [MAX_TGT-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic [MAX_TGT-1:0] onehot_o,
  output logic               single_o
);

  // Scan from the top so the lowest set bit wins the last assignment.
  always_comb begin
    idx_o = '0;
    for (int k = MAX_TGT - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = IDX_W'(k);
    end
  end

  assign onehot_o = req_i & (~req_i + MAX_TGT'(1));
  assign single_o = (req_i != '0) && ((req_i & (req_i - MAX_TGT'(1))) == '0);

endmodule

// File: rtl/target_box_sequencer.sv
// Target box sequencer: snapshots the detector's target list on each frame
// start, qualifies the slots and streams the qualifying boxes out one per
// transfer, lowest slot first.
//
// Stream handshake: box_valid is raised only in EMIT; while box_valid is high
// and box_ready is low, box_idx and all box coordinates are held; a transfer
// happens on each clock where box_valid && box_ready; box_valid only falls
// without a transfer when a new frame edge aborts the list or on reset.
//
// Optional macro BOX_SIZE_FILTER_EN: when defined, a slot also needs
// width >= min_w and height >= min_h to qualify.
module target_box_sequencer
  import tgt_pkg::*;
#(
  parameter int NUM_TGT   = 16,
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       per_frame_vsync,
  input  logic [NUM_TGT*SLOT_W-1:0]  target_pos_bus,
  input  logic [COORD_W-1:0]         min_w,
  input  logic [COORD_W-1:0]         min_h,
  output logic                       box_valid,
  input  logic                       box_ready,
  output logic [IDX_W-1:0]           box_idx,
  output logic [COORD_W-1:0]         box_left,
  output logic [COORD_W-1:0]         box_top,
  output logic [COORD_W-1:0]         box_right,
  output logic [COORD_W-1:0]         box_bottom,
  output logic                       box_last,
  output logic                       frame_done,
  output logic [CNT_W-1:0]           box_cnt,
  output logic                       overrun,
  output state_e                     dbg_state
);

  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(IMG_HDISP - 1);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(IMG_VDISP - 1);

  logic               vs_q;
  logic               vs_edge;
  state_e             state_q, state_d;
  slot_t              snap_q [NUM_TGT];
  logic [NUM_TGT-1:0] qual_q, qual_d, qual_calc;
  logic [CNT_W-1:0]   box_cnt_q, box_cnt_d, qual_pop;
  logic               slot_ok;

  logic [MAX_TGT-1:0] pick_req;
  logic [MAX_TGT-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_single;
  slot_t              cur_slot;

`ifdef BOX_SIZE_FILTER_EN
  logic [COORD_W:0]   box_w, box_h;
`else
  logic               unused_min_size;
  assign unused_min_size = ^{min_w, min_h};
`endif

  assign vs_edge   = per_frame_vsync & ~vs_q;
  assign dbg_state = state_q;
  assign box_cnt   = box_cnt_q;

  assign pick_req = MAX_TGT'(qual_q);
  assign cur_slot = snap_q[pick_idx];

  tgt_pick_lowest u_pick (
    .req_i    (pick_req),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot),
    .single_o (pick_single)
  );

  // Qualify every snapshotted slot and count the qualifying ones.
  always_comb begin
    qual_calc = '0;
    qual_pop  = '0;
    slot_ok   = 1'b0;
`ifdef BOX_SIZE_FILTER_EN
    box_w     = '0;
    box_h     = '0;
`endif
    for (int k = 0; k < NUM_TGT; k++) begin
      slot_ok = snap_q[k].valid &&
                (snap_q[k].right >= snap_q[k].left) &&
                (snap_q[k].bottom >= snap_q[k].top);
`ifdef BOX_SIZE_FILTER_EN
      // One extra bit so a full-width box (1024) does not wrap to zero.
      box_w   = {1'b0, snap_q[k].right}  - {1'b0, snap_q[k].left} + (COORD_W+1)'(1);
      box_h   = {1'b0, snap_q[k].bottom} - {1'b0, snap_q[k].top}  + (COORD_W+1)'(1);
      slot_ok = slot_ok && (box_w >= {1'b0, min_w}) && (box_h >= {1'b0, min_h});
`endif
      qual_calc[k] = slot_ok;
      qual_pop     = qual_pop + CNT_W'(slot_ok);
    end
  end

  // Next-state logic; a frame edge outside IDLE restarts the sequence.
  always_comb begin
    state_d   = state_q;
    qual_d    = qual_q;
    box_cnt_d = box_cnt_q;
    case (state_q)
      ST_IDLE: ;
      ST_ARM:  state_d = ST_QUAL;
      ST_QUAL: begin
        qual_d    = qual_calc;
        box_cnt_d = qual_pop;
        state_d   = (qual_calc != '0) ? ST_EMIT : ST_DONE;
      end
      ST_EMIT: begin
        if (box_ready) begin
          qual_d = qual_q & ~pick_onehot[NUM_TGT-1:0];
          if (pick_single) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (vs_edge) state_d = ST_ARM;
  end

  // Stream and status outputs decoded from the current state.
  always_comb begin
    box_valid  = 1'b0;
    box_idx    = '0;
    box_left   = '0;
    box_top    = '0;
    box_right  = '0;
    box_bottom = '0;
    box_last   = 1'b0;
    if (state_q == ST_EMIT) begin
      box_valid  = 1'b1;
      box_idx    = pick_idx;
      box_left   = cur_slot.left;
      box_top    = cur_slot.top;
      box_right  = clamp_coord(cur_slot.right, H_LIM);
      box_bottom = clamp_coord(cur_slot.bottom, V_LIM);
      box_last   = pick_single;
    end
  end

  // An aborted frame never reports completion, even from DONE.
  assign frame_done = (state_q == ST_DONE) && !vs_edge;
  assign overrun    = vs_edge && (state_q != ST_IDLE);

  // Control registers: edge detector, FSM state, pending mask, count.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      state_q   <= ST_IDLE;
      qual_q    <= '0;
      box_cnt_q <= '0;
    end else begin
      vs_q      <= per_frame_vsync;
      state_q   <= state_d;
      qual_q    <= qual_d;
      box_cnt_q <= box_cnt_d;
    end
  end

  // Snapshot the list one cycle after the edge, once the detector has updated it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TGT; k++) snap_q[k] <= '0;
    end else if (state_q == ST_ARM) begin
      for (int k = 0; k < NUM_TGT; k++) snap_q[k] <= target_pos_bus[k*SLOT_W +: SLOT_W];
    end
  end

endmodule

// File: tb/tb_target_box_sequencer.sv
// Bench for target_box_sequencer: table of single-slot frames, hand-written
// multi-cycle sequences and random frames against a list-based model.
module tb_target_box_sequencer;
  import tgt_pkg::*;

  localparam int NT = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  per_frame_vsync = 1'b0;
  logic [NT*SLOT_W-1:0]  target_pos_bus = '0;
  logic [COORD_W-1:0]    min_w = 10'd16;
  logic [COORD_W-1:0]    min_h = 10'd16;
  logic                  box_valid;
  logic                  box_ready = 1'b0;
  logic [IDX_W-1:0]      box_idx;
  logic [COORD_W-1:0]    box_left, box_top, box_right, box_bottom;
  logic                  box_last, frame_done, overrun;
  logic [CNT_W-1:0]      box_cnt;
  state_e                dbg_state;

  target_box_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .per_frame_vsync (per_frame_vsync),
    .target_pos_bus  (target_pos_bus),
    .min_w           (min_w),
    .min_h           (min_h),
    .box_valid       (box_valid),
    .box_ready       (box_ready),
    .box_idx         (box_idx),
    .box_left        (box_left),
    .box_top         (box_top),
    .box_right       (box_right),
    .box_bottom      (box_bottom),
    .box_last        (box_last),
    .frame_done      (frame_done),
    .box_cnt         (box_cnt),
    .overrun         (overrun),
    .dbg_state       (dbg_state)
  );

  // Clock and reset timing
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  typedef struct packed {
    logic [3:0] idx;
    logic [9:0] l, t, r, b;
  } box_t;

  box_t exp_q[$];
  int   exp_cnt;
  int   n_checks = 0;
  int   n_pass   = 0;

  int s_v[NT], s_l[NT], s_t[NT], s_r[NT], s_b[NT];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver helpers for the slot list
  task automatic clear_slots();
    for (int k = 0; k < NT; k++) begin
      s_v[k] = 0; s_l[k] = 0; s_t[k] = 0; s_r[k] = 0; s_b[k] = 0;
    end
  endtask

  task automatic set_slot(input int k, input int v, input int l, input int t,
                          input int r, input int b);
    s_v[k] = v; s_l[k] = l; s_t[k] = t; s_r[k] = r; s_b[k] = b;
  endtask

  task automatic pack_bus();
    for (int k = 0; k < NT; k++)
      target_pos_bus[k*SLOT_W +: SLOT_W] = {1'(s_v[k]), 10'(s_b[k]), 10'(s_r[k]),
                                            10'(s_t[k]), 10'(s_l[k])};
  endtask

  // Reference model: list of boxes expected for the current slot arrays.
  task automatic build_expect();
    bit ok;
    exp_q.delete();
    exp_cnt = 0;
    for (int k = 0; k < NT; k++) begin
      ok = (s_v[k] != 0) && (s_r[k] >= s_l[k]) && (s_b[k] >= s_t[k]);
`ifdef BOX_SIZE_FILTER_EN
      ok = ok && ((s_r[k] - s_l[k] + 1) >= int'(min_w)) && ((s_b[k] - s_t[k] + 1) >= int'(min_h));
`endif
      if (ok) begin
        exp_q.push_back('{idx: 4'(k), l: 10'(s_l[k]), t: 10'(s_t[k]),
                          r: 10'((s_r[k] > 639) ? 639 : s_r[k]),
                          b: 10'((s_b[k] > 479) ? 479 : s_b[k])});
        exp_cnt++;
      end
    end
  endtask

  // Raise vsync from IDLE and walk to the third cycle after the edge.
  task automatic start_frame();
    pack_bus();
    per_frame_vsync = 1'b1;
    #1;
    check("start_no_overrun", int'(overrun), 0);
    tick();
    per_frame_vsync = 1'b0;
    check("arm_valid", int'(box_valid), 0);
    check("arm_state", int'(dbg_state), int'(ST_ARM));
    tick();
    check("qual_valid", int'(box_valid), 0);
    tick();
    if (exp_q.size() > 0) check("latency_valid", int'(box_valid), 1);
    else                  check("latency_done", int'(frame_done), 1);
  endtask

  // Consume the stream until frame_done; mode 0 ready=1, 1 random, 2 stall idx 5 x4.
  task automatic emit_loop(input int mode, output int xfers);
    int cyc, stall;
    bit done_seen, rdy;
    xfers = 0; cyc = 0; stall = 0; done_seen = 0;
    while (!done_seen && cyc < 300) begin
      rdy = 1'b0;
      if (frame_done) begin
        done_seen = 1'b1;
        check("done_cnt", int'(box_cnt), exp_cnt);
        check("done_pending", exp_q.size(), 0);
        check("done_valid", int'(box_valid), 0);
      end else if (box_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_box_idx", int'(box_idx), -1);
        end else begin
          check("idx",    int'(box_idx),    int'(exp_q[0].idx));
          check("left",   int'(box_left),   int'(exp_q[0].l));
          check("top",    int'(box_top),    int'(exp_q[0].t));
          check("right",  int'(box_right),  int'(exp_q[0].r));
          check("bottom", int'(box_bottom), int'(exp_q[0].b));
          check("last",   int'(box_last),   (exp_q.size() == 1) ? 1 : 0);
          case (mode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            default: begin
              if (exp_q[0].idx == 4'd5 && stall < 4) stall++;
              else rdy = 1'b1;
            end
          endcase
          if (rdy) begin
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
      box_ready = rdy;
      tick();
      cyc++;
    end
    box_ready = 1'b0;
    if (!done_seen) check("frame_timeout", cyc, -1);
  endtask

  typedef struct {
    int v, l, t, r, b;
    int exp_n, exp_r, exp_b;
  } vec_t;

  vec_t vecs[7];
  int   xf;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", int'(box_valid), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_cnt", int'(box_cnt), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Three slots, always ready, then same list with a 4-cycle stall on idx 5
    clear_slots();
    set_slot(2, 1, 10, 20, 30, 40);
    set_slot(5, 1, 100, 50, 180, 200);
    set_slot(9, 1, 300, 300, 400, 450);
    build_expect();
    check("model_cnt3", exp_cnt, 3);
    start_frame();
    emit_loop(0, xf);
    check("xfers_ready", xf, 3);
    build_expect();
    start_frame();
    emit_loop(2, xf);
    check("xfers_stall", xf, 3);

    // Single-slot table: ordering, equality, clamp and validity cases
    vecs[0] = '{1, 100, 50, 180, 200, 1, 180, 200};
    vecs[1] = '{1, 20, 0, 10, 100, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 1023, 1023, 1, 639, 479};
    vecs[3] = '{0, 10, 10, 200, 200, 0, 0, 0};
    vecs[4] = '{1, 0, 300, 100, 299, 0, 0, 0};
    vecs[5] = '{1, 600, 400, 650, 479, 1, 639, 479};
`ifdef BOX_SIZE_FILTER_EN
    vecs[6] = '{1, 5, 5, 5, 5, 0, 0, 0};
`else
    vecs[6] = '{1, 5, 5, 5, 5, 1, 5, 5};
`endif
    for (int i = 0; i < 7; i++) begin
      clear_slots();
      set_slot(i + 1, vecs[i].v, vecs[i].l, vecs[i].t, vecs[i].r, vecs[i].b);
      exp_q.delete();
      exp_cnt = vecs[i].exp_n;
      if (vecs[i].exp_n != 0)
        exp_q.push_back('{idx: 4'(i + 1), l: 10'(vecs[i].l), t: 10'(vecs[i].t),
                          r: 10'(vecs[i].exp_r), b: 10'(vecs[i].exp_b)});
      start_frame();
      emit_loop(0, xf);
      check("table_xfers", xf, vecs[i].exp_n);
    end

    // All slots invalid
    clear_slots();
    build_expect();
    start_frame();
    emit_loop(0, xf);
    check("empty_xfers", xf, 0);

    // Size filter boundary: 15x40 and 16x16
    clear_slots();
    set_slot(3, 1, 10, 0, 24, 39);
    set_slot(4, 1, 100, 100, 115, 115);
    build_expect();
`ifdef BOX_SIZE_FILTER_EN
    check("model_filter", exp_cnt, 1);
`else
    check("model_filter", exp_cnt, 2);
`endif
    start_frame();
    emit_loop(1, xf);

    // Overrun: second edge while a box is stalled
    clear_slots();
    set_slot(2, 1, 10, 20, 30, 40);
    set_slot(5, 1, 100, 50, 180, 200);
    set_slot(9, 1, 300, 300, 400, 450);
    build_expect();
    start_frame();
    tick();
    tick();
    check("stall_hold_valid", int'(box_valid), 1);
    check("stall_hold_idx", int'(box_idx), 2);
    clear_slots();
    set_slot(7, 1, 200, 100, 260, 160);
    set_slot(12, 1, 1000, 470, 1023, 1000);
    build_expect();
    pack_bus();
    per_frame_vsync = 1'b1;
    #1;
    check("overrun_pulse", int'(overrun), 1);
    check("abort_no_done", int'(frame_done), 0);
    tick();
    per_frame_vsync = 1'b0;
    check("overrun_one_cycle", int'(overrun), 0);
    check("abort_valid_drop", int'(box_valid), 0);
    tick();
    check("abort_qual_done", int'(frame_done), 0);
    tick();
    check("abort_restart_valid", int'(box_valid), 1);
    emit_loop(0, xf);
    check("abort_new_xfers", xf, 2);

    // Reset while a box is presented
    clear_slots();
    set_slot(3, 1, 40, 40, 90, 90);
    build_expect();
    start_frame();
    rst = 1'b1;
    tick();
    check("midrst_valid", int'(box_valid), 0);
    check("midrst_cnt", int'(box_cnt), 0);
    check("midrst_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;
    tick();
    check("postrst_valid", int'(box_valid), 0);

    // Random frames with random backpressure
    for (int f = 0; f < 25; f++) begin
      clear_slots();
      for (int k = 0; k < NT; k++) begin
        int l, t, r, b;
        l = $urandom_range(0, 1023);
        t = $urandom_range(0, 1023);
        r = ($urandom_range(0, 1) != 0) ? l + $urandom_range(0, 40) : $urandom_range(0, 1023);
        b = ($urandom_range(0, 1) != 0) ? t + $urandom_range(0, 40) : $urandom_range(0, 1023);
        if (r > 1023) r = 1023;
        if (b > 1023) b = 1023;
        set_slot(k, ($urandom_range(0, 3) != 0) ? 1 : 0, l, t, r, b);
      end
      build_expect();
      start_frame();
      emit_loop(1, xf);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
